// File: rtl/game24_pkg.sv
// rtl/game24_pkg.sv - shared states, key codes and helpers for the 24-game controller
package game24_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DEAL, ST_SEL_A, ST_SEL_B, ST_SEL_OP, ST_DONE
    } state_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_DIV  = 4'd13;

    function automatic logic is_slot(input logic [3:0] k);
        return (k >= 4'd1) && (k <= 4'd4);
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    function automatic op_t key_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

    // Maps a random nibble onto a card face 1..13.
    function automatic logic [3:0] card(input logic [3:0] n);
        return (n % 4'd13) + 4'd1;
    endfunction

endpackage

// File: rtl/game24_fsm_lfsr16.sv
// rtl/game24_fsm_lfsr16.sv - free-running 16-bit Galois LFSR, taps 16,14,13,11
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/game24_fsm.sv
// rtl/game24_fsm.sv - 24-game control FSM: deal, slot/operator selection, ALU, restart
module game24_fsm
    import game24_pkg::*;
#(
    parameter int          W    = 10,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         START,
    input  logic         RESTART,
    input  logic [3:0]   decode,
    output logic [W-1:0] num1,
    output logic [W-1:0] num2,
    output logic [W-1:0] num3,
    output logic [W-1:0] num4
);

    // Double width so a large product can never wrap below the overflow check.
    localparam int RW = 2 * W;

    state_t        state;
    logic [W-1:0]  num  [4];
    logic [W-1:0]  orig [4];
    logic [3:0]    valid;
    logic [1:0]    sel_a, sel_b;
    logic [3:0]    key_q;
    logic [15:0]   lfsr_q;

    logic          press;
    logic [1:0]    kidx;
    logic          slot_ok;
    logic [W-1:0]  na, nb;
    logic [RW-1:0] r;
    logic          reject;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign press   = (key_q == KEY_NONE) && (decode != KEY_NONE);
    assign kidx    = 2'(decode - 4'd1);
    assign slot_ok = is_slot(decode) && valid[kidx];

    always_comb begin
        na     = num[sel_a];
        nb     = num[sel_b];
        r      = '0;
        reject = 1'b0;
        case (key_op(decode))
            OP_ADD: r = RW'(na) + RW'(nb);
            OP_SUB: begin
                r      = RW'(na) - RW'(nb);
                reject = na < nb;
            end
            OP_MUL: r = RW'(na) * RW'(nb);
            OP_DIV: begin
                reject = (nb == '0);
                r      = reject ? '0 : RW'(na / nb);
            end
            default: r = '0;
        endcase
        if (|r[RW-1:W]) reject = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            key_q <= KEY_NONE;
            valid <= 4'h0;
            sel_a <= 2'd0;
            sel_b <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                num[i]  <= '0;
                orig[i] <= '0;
            end
        end else begin
            key_q <= decode;
            if (START) begin
                state <= ST_DEAL;
            end else if (RESTART && state != ST_IDLE && state != ST_DEAL) begin
                for (int i = 0; i < 4; i++) num[i] <= orig[i];
                valid <= 4'hF;
                state <= ST_SEL_A;
            end else begin
                case (state)
                    ST_DEAL: begin
                        for (int i = 0; i < 4; i++) begin
                            num[i]  <= W'(card(lfsr_q[4*i +: 4]));
                            orig[i] <= W'(card(lfsr_q[4*i +: 4]));
                        end
                        valid <= 4'hF;
                        state <= ST_SEL_A;
                    end
                    ST_SEL_A: if (press && slot_ok) begin
                        sel_a <= kidx;
                        state <= ST_SEL_B;
                    end
                    ST_SEL_B: if (press && slot_ok && kidx != sel_a) begin
                        sel_b <= kidx;
                        state <= ST_SEL_OP;
                    end
                    ST_SEL_OP: if (press && is_op(decode)) begin
                        if (!reject) begin
                            num[sel_b]   <= r[W-1:0];
                            num[sel_a]   <= '0;
                            valid[sel_a] <= 1'b0;
                            state <= ($countones(valid) == 2) ? ST_DONE : ST_SEL_A;
                        end else begin
                            state <= ST_SEL_A;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    assign num1 = num[0];
    assign num2 = num[1];
    assign num3 = num[2];
    assign num4 = num[3];

endmodule

// File: tb/tb_game24_fsm.sv
// tb/tb_game24_fsm.sv - scoreboard bench for game24_fsm against a card-level game model
module tb_game24_fsm;

    localparam int          W    = 10;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int P_IDLE = 0, P_DEAL = 1, P_A = 2, P_B = 3, P_OP = 4, P_DONE = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         START = 1'b0;
    logic         RESTART = 1'b0;
    logic [3:0]   decode = 4'd0;
    logic [W-1:0] num1, num2, num3, num4;

    always #5 clk = ~clk;

    game24_fsm #(.W(W), .SEED(SEED)) dut (
        .clk     (clk),
        .rst     (rst),
        .START   (START),
        .RESTART (RESTART),
        .decode  (decode),
        .num1    (num1),
        .num2    (num2),
        .num3    (num3),
        .num4    (num4)
    );

    // ---------------- reference model ----------------
    int          m_num  [4];
    int          m_orig [4];
    bit          m_val  [4];
    int          m_phase = P_IDLE;
    int          m_a, m_b;
    logic [15:0] m_lfsr;
    logic [15:0] force_val;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] mask;
        mask = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
        return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_num[i] = 0; m_orig[i] = 0; m_val[i] = 0;
        end
        m_phase = P_IDLE;
    endfunction

    function automatic void model_deal(input logic [15:0] s);
        for (int i = 0; i < 4; i++) begin
            m_num[i]  = ((s >> (4 * i)) & 16'hF) % 13 + 1;
            m_orig[i] = m_num[i];
            m_val[i]  = 1;
        end
        m_phase = P_A;
    endfunction

    function automatic void model_restart();
        if (m_phase != P_IDLE && m_phase != P_DEAL) begin
            for (int i = 0; i < 4; i++) begin
                m_num[i] = m_orig[i]; m_val[i] = 1;
            end
            m_phase = P_A;
        end
    endfunction

    function automatic void model_key(input int k);
        int na, nb, res, left;
        bit ok;
        case (m_phase)
            P_A: if (k >= 1 && k <= 4 && m_val[k-1]) begin
                m_a = k - 1; m_phase = P_B;
            end
            P_B: if (k >= 1 && k <= 4 && m_val[k-1] && (k - 1) != m_a) begin
                m_b = k - 1; m_phase = P_OP;
            end
            P_OP: if (k >= 10 && k <= 13) begin
                na = m_num[m_a]; nb = m_num[m_b]; ok = 1; res = 0;
                case (k)
                    10: res = na + nb;
                    11: if (na < nb) ok = 0; else res = na - nb;
                    12: res = na * nb;
                    default: if (nb == 0) ok = 0; else res = na / nb;
                endcase
                if (res > (1 << W) - 1) ok = 0;
                if (ok) begin
                    m_num[m_b] = res; m_num[m_a] = 0; m_val[m_a] = 0;
                    left = 0;
                    for (int i = 0; i < 4; i++) left += int'(m_val[i]);
                    m_phase = (left == 1) ? P_DONE : P_A;
                end else begin
                    m_phase = P_A;
                end
            end
            default: ;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [4*W-1:0] exp_q [$];
    string          name_q [$];
    int             tests = 0;
    int             fails = 0;

    function automatic void expect_now(input string nm);
        exp_q.push_back({W'(m_num[3]), W'(m_num[2]), W'(m_num[1]), W'(m_num[0])});
        name_q.push_back(nm);
    endfunction

    initial begin : monitor
        logic [4*W-1:0] e, got;
        string nm;
        forever begin
            @(clk);
            #1;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {num4, num3, num2, num1};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL %s: got num1..4=%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                             nm, got[W-1:0], got[2*W-1:W], got[3*W-1:2*W], got[4*W-1:3*W],
                             e[W-1:0], e[2*W-1:W], e[3*W-1:2*W], e[4*W-1:3*W]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input int k);
        @(negedge clk) decode = 4'(k);
        @(negedge clk) decode = 4'd0;
        model_key(k);
    endtask

    task automatic keys3(input int k1, input int k2, input int k3);
        press(k1); press(k2); press(k3);
    endtask

    task automatic restart_pulse();
        @(negedge clk) RESTART = 1'b1;
        @(negedge clk) RESTART = 1'b0;
        model_restart();
    endtask

    task automatic deal(input int hold);
        @(negedge clk) START = 1'b1;
        repeat (hold) @(negedge clk);
        START = 1'b0;
        model_deal(m_lfsr);
        @(negedge clk);
    endtask

    task automatic deal_forced(input logic [15:0] v);
        @(negedge clk) START = 1'b1;
        @(negedge clk) START = 1'b0;
        force_val = v;
        force dut.u_lfsr.q = force_val;
        model_deal(v);
        @(negedge clk);
        release dut.u_lfsr.q;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        model_reset();
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        model_reset();
        repeat (2) @(negedge clk);
        expect_now("reset_zero");
        rst = 1'b1;
        press(1); press(10); press(3);
        restart_pulse();
        expect_now("idle_keys_ignored");

        repeat (7) @(negedge clk);
        deal(40);
        expect_now("deal_after_40");

        press(1); press(2);
        deal(3);
        expect_now("start_in_sel_op");

        for (int g = 0; g < 5; g++) begin
            deal($urandom_range(1, 20));
            expect_now("rand_deal");
            for (int e = 0; e < 25; e++) begin
                case ($urandom_range(0, 9))
                    0:       restart_pulse();
                    1, 2:    press($urandom_range(0, 15));
                    3, 5, 7: press($urandom_range(10, 13));
                    default: press($urandom_range(1, 4));
                endcase
                expect_now("rand_step");
            end
        end

        deal_forced(16'hC732);
        expect_now("hand_3_4_8_13");
        keys3(4, 2, 11);
        expect_now("sub_13_4");
        keys3(3, 2, 12);
        expect_now("mul_8_9");
        keys3(2, 1, 13);
        expect_now("div_to_24");
        press(1); press(2); press(10);
        expect_now("done_frozen");

        deal_forced(16'hBA77);
        keys3(1, 2, 13);
        expect_now("div_8_8");
        press(1);
        keys3(3, 4, 10);
        expect_now("empty_slot_ignored");
        restart_pulse();
        expect_now("restart_restore");

        deal_forced(16'h7233);
        keys3(1, 2, 11);
        expect_now("sub_4_4");
        keys3(3, 2, 13);
        expect_now("div_by_zero_rej");
        keys3(3, 4, 11);
        expect_now("neg_sub_rej");
        press(4); press(4); press(2); press(10);
        expect_now("same_slot_ignored");
        @(negedge clk) decode = 4'd3;
        repeat (4) @(negedge clk);
        decode = 4'd2;
        repeat (3) @(negedge clk);
        decode = 4'd0;
        model_key(3);
        press(13);
        expect_now("held_key_single");
        press(2); press(12);
        expect_now("held_then_mul");
        restart_pulse();
        expect_now("restart_from_done");

        deal_forced(16'hCCCC);
        keys3(1, 2, 12);
        keys3(2, 3, 12);
        expect_now("mul_ovf_rej");
        keys3(3, 4, 12);
        keys3(2, 4, 12);
        expect_now("mul_big_ovf_rej");
        keys3(2, 4, 10);
        expect_now("add_338");

        deal_forced(16'hC732);
        press(1); press(2);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        expect_now("async_reset_mid_move");
        @(negedge clk) rst = 1'b1;
        press(1); press(2); press(10);
        expect_now("keys_after_reset");

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
